// File: rtl/fft_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : fft_pkg                                            |
// | Description : Shared FFT types and base-4 digit-reversal helper. |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package fft_pkg;

    localparam int WIDTH      = 16;
    localparam int FULL_WIDTH = 2 * WIDTH;

    // Widest address the reversal helper handles.
    localparam int c_rev_w = 16;

    // Packed complex word as written by the butterfly stages.
    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } complex_t;

    // Reverse the order of the 2-bit digits in the low addr_w bits of k.
    function automatic logic [c_rev_w-1:0] digitrev4(input logic [c_rev_w-1:0] k,
                                                     input int                  addr_w);
        logic [c_rev_w-1:0] r;
        int                 src;
        r   = '0;
        src = 0;
        for (int i = 0; i < c_rev_w / 2; i++) begin
            if (i < addr_w / 2) begin
                src         = addr_w - 2 - 2 * i;
                r[2*i +: 2] = k[src +: 2];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : bin_fifo                                           |
// | Description : First-word fall-through FIFO for output bins.      |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module bin_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  c_ptr_last = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_depth    = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fft_bin_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fft_bin_reader                                     |
// | Description : Reads an FFT frame in digit-reversed order, emits  |
// |               natural-order magnitude-squared bins with          |
// |               valid/ready backpressure.                          |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module fft_bin_reader #(
    parameter int WIDTH      = 16,
    parameter int FULL_WIDTH = 32,
    parameter int N_POINTS   = 64,
    parameter int ADDR_W     = 6,
    parameter int HALF_SPEC  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [FULL_WIDTH-1:0] rd_data,
    output logic                  bin_valid,
    input  logic                  bin_ready,
    output logic [ADDR_W-1:0]     bin_index,
    output logic [2*WIDTH-1:0]    bin_mag,
    output logic                  bin_last,
    output logic                  frame_done
);

    import fft_pkg::*;

    localparam int                  c_n_out  = (HALF_SPEC != 0) ? N_POINTS / 2 : N_POINTS;
    localparam int                  c_cnt_w  = $clog2(FIFO_DEPTH + 1);
    localparam int                  c_fifo_w = ADDR_W + 2 * WIDTH + 1;
    localparam logic [ADDR_W-1:0]   c_k_last = ADDR_W'(c_n_out - 1);
    localparam logic [c_cnt_w:0]    c_depth  = (c_cnt_w + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]               r_state;
    logic                     r_busy;
    logic                     r_frame_done;
    logic                     r_rd_en;
    logic [ADDR_W-1:0]        r_rd_addr;
    logic [ADDR_W-1:0]        r_k;
    logic [c_cnt_w-1:0]       r_in_flight;
    logic [ADDR_W-1:0]        r_idx1, r_idx2, r_idx3;
    logic                     r_last1, r_last2, r_last3;
    logic                     r_v2, r_v3;
    logic signed [WIDTH-1:0]  r_re, r_im;

    logic                     w_issue, w_room, w_pop, w_xfer_last;
    logic [c_cnt_w:0]         w_occ;
    logic signed [2*WIDTH-1:0] w_re_ext, w_im_ext, w_re_sq, w_im_sq;
    logic [2*WIDTH-1:0]       w_mag;
    logic [c_fifo_w-1:0]      w_fifo_in, w_fifo_out;
    logic [c_cnt_w-1:0]       w_fifo_count;
    logic                     w_fifo_full, w_fifo_empty;
    logic                     w_unused_full;

    // Reads already issued plus bins buffered must fit the FIFO; a pop this cycle frees a slot.
    assign w_pop       = bin_valid && bin_ready;
    assign w_xfer_last = w_pop && bin_last;
    assign w_occ       = {1'b0, r_in_flight} + {1'b0, w_fifo_count} - {{c_cnt_w{1'b0}}, w_pop};
    assign w_room      = (w_occ < c_depth);
    assign w_issue     = ((r_state == c_st_idle) && start) || ((r_state == c_st_issue) && w_room);

    // Control FSM: read issue, address generation, in-flight tracking and frame status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_k          <= '0;
            r_in_flight  <= '0;
            r_idx1       <= '0;
            r_last1      <= 1'b0;
        end else begin
            r_rd_en      <= w_issue;
            r_frame_done <= 1'b0;
            r_in_flight  <= r_in_flight + c_cnt_w'(w_issue) - c_cnt_w'(r_v3);
            if (w_issue) begin
                r_rd_addr <= ADDR_W'(digitrev4(c_rev_w'(r_k), ADDR_W));
                r_idx1    <= r_k;
                r_last1   <= (r_k == c_k_last);
                r_k       <= r_k + ADDR_W'(1);
            end
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= (c_k_last == '0) ? c_st_drain : c_st_issue;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_issue: begin
                    if (w_issue && (r_k == c_k_last)) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (w_xfer_last) begin
                        r_state      <= c_st_idle;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_k          <= '0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Data pipeline: track the index alongside the RAM latency, then capture re/im.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_idx2  <= '0;
            r_last2 <= 1'b0;
            r_v3    <= 1'b0;
            r_idx3  <= '0;
            r_last3 <= 1'b0;
            r_re    <= '0;
            r_im    <= '0;
        end else begin
            r_v2    <= r_rd_en;
            r_idx2  <= r_idx1;
            r_last2 <= r_last1;
            r_v3    <= r_v2;
            r_idx3  <= r_idx2;
            r_last3 <= r_last2;
            if (r_v2) begin
                r_re <= rd_data[FULL_WIDTH-1:WIDTH];
                r_im <= rd_data[WIDTH-1:0];
            end
        end
    end

    // Squares of sign-extended components; the sum is at most 2^31 and fits unsigned.
    assign w_re_ext  = {{WIDTH{r_re[WIDTH-1]}}, r_re};
    assign w_im_ext  = {{WIDTH{r_im[WIDTH-1]}}, r_im};
    assign w_re_sq   = w_re_ext * w_re_ext;
    assign w_im_sq   = w_im_ext * w_im_ext;
    assign w_mag     = w_re_sq + w_im_sq;
    assign w_fifo_in = {r_idx3, w_mag, r_last3};

    bin_fifo #(
        .DATA_W (c_fifo_w),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (c_cnt_w)
    ) u_bin_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_v3),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Full is implied by the occupancy rule, so it is not needed for flow control.
    assign w_unused_full = w_fifo_full;

    assign busy       = r_busy;
    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign frame_done = r_frame_done;
    assign bin_valid  = !w_fifo_empty;
    assign bin_index  = w_fifo_out[c_fifo_w-1 -: ADDR_W];
    assign bin_mag    = w_fifo_out[2*WIDTH:1];
    assign bin_last   = w_fifo_out[0];

endmodule
`default_nettype wire
